// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: parametrised single-clock FIFO with programmable almost-full/almost-empty levels.
// Optional sticky overflow/underflow tracking is built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_pro #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_r;
  logic [ADDR_W-1:0]     rd_ptr_r;
  logic [ADDR_W:0]       count_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Acceptance uses the registered full/empty, so a full FIFO rejects a
  // same-cycle write even when a read frees a slot.
  assign wr_acc_s = wr_cs & wr_en & ~full;
  assign rd_acc_s = rd_cs & rd_en & ~empty;

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      data_out <= {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        data_out <= mem_r[rd_ptr_r];
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{ADDR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign count        = count_r;
  assign full         = (count_r == DEPTH_C);
  assign empty        = (count_r == {(ADDR_W+1){1'b0}});
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_cs && wr_en && full) begin
        overflow_r <= 1'b1;
      end
      if (rd_cs && rd_en && empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed self-checking bench for sync_fifo_pro (DEPTH=16, DATA_WIDTH=8).
module tb_sync_fifo_pro;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_cs, wr_en, rd_cs, rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_pro #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++;
    if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
      bad++; $display("FAIL reset_flags got=%b exp=0011", {full, almost_full, empty, almost_empty});
    end
    total++;
    if ({data_out, overflow, underflow} !== 10'd0) begin
      bad++; $display("FAIL reset_dout_err got=%h/%b%b exp=00/00", data_out, overflow, underflow);
    end
    // chip selects low: requests ignored, no error flags
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
    step();
    idle();
    total++;
    if ({count, overflow, underflow} !== 7'd0) begin
      bad++; $display("FAIL cs_low got=%0d/%b%b exp=0/00", count, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'(i);
      step();
      total++;
      if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      total++;
      if ({almost_full, full} !== {(i + 1 >= 14), (i + 1 == 16)}) begin
        bad++; $display("FAIL fill_flags i=%0d got=%b%b exp=%b%b", i, almost_full, full, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'hAA;
    step();
    idle();
    total++;
    if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    total++;
    if (overflow !== ERR_EN) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ERR_EN); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_cs = 1'b1; rd_en = 1'b1;
      step();
      total++;
      if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
      total++;
      if ({count, almost_empty, empty} !== {5'(15 - i), (15 - i <= 2), (i == 15)}) begin
        bad++; $display("FAIL drain_status i=%0d got=%0d/%b%b exp=%0d/%b%b", i, count, almost_empty, empty,
                        15 - i, (15 - i <= 2), (i == 15));
      end
    end
    idle();
  endtask

  task automatic test_underflow();
    wr_cs = 1'b1; wr_en = 1'b1; rd_cs = 1'b1; rd_en = 1'b1; data_in = 8'h55;
    step();
    idle();
    total++;
    if (count !== 5'd1) begin bad++; $display("FAIL udf_count got=%0d exp=1", count); end
    total++;
    if (underflow !== ERR_EN) begin bad++; $display("FAIL udf_flag got=%b exp=%b", underflow, ERR_EN); end
    total++;
    if (data_out !== 8'h0F) begin bad++; $display("FAIL udf_no_bypass got=%h exp=0f", data_out); end
    rd_cs = 1'b1; rd_en = 1'b1;
    step();
    idle();
    total++;
    if ({data_out, count} !== {8'h55, 5'd0}) begin
      bad++; $display("FAIL udf_readback got=%h/%0d exp=55/0", data_out, count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    // 12 writes (0..11), 4 reads (0..3): count 8, rd_ptr 4, wr_ptr 12
    for (int i = 0; i < 12; i++) begin
      wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'(i);
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_cs = 1'b1; rd_en = 1'b1;
      step();
    end
    idle();
    total++;
    if ({count, data_out} !== {5'd8, 8'd3}) begin bad++; $display("FAIL wrap_setup got=%0d/%h exp=8/03", count, data_out); end
    for (int k = 0; k < 10; k++) begin
      wr_cs = 1'b1; wr_en = 1'b1; rd_cs = 1'b1; rd_en = 1'b1; data_in = 8'(12 + k);
      step();
      total++;
      if ({count, data_out} !== {5'd8, 8'(4 + k)}) begin
        bad++; $display("FAIL wrap_simul k=%0d got=%0d/%h exp=8/%h", k, count, data_out, 8'(4 + k));
      end
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      rd_cs = 1'b1; rd_en = 1'b1;
      step();
      total++;
      if (data_out !== 8'(14 + k)) begin bad++; $display("FAIL wrap_drain k=%0d got=%h exp=%h", k, data_out, 8'(14 + k)); end
    end
    idle();
    total++;
    if ({empty, overflow, underflow} !== 3'b100) begin
      bad++; $display("FAIL wrap_end got=%b%b%b exp=100", empty, overflow, underflow);
    end
  endtask

  task automatic test_reset_mid();
    // underflow attempt on empty, then 5 writes and one read
    rd_cs = 1'b1; rd_en = 1'b1;
    step();
    idle();
    total++;
    if (underflow !== ERR_EN) begin bad++; $display("FAIL mid_udf got=%b exp=%b", underflow, ERR_EN); end
    for (int i = 0; i < 5; i++) begin
      wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'(8'h31 + i);
      step();
    end
    idle();
    rd_cs = 1'b1; rd_en = 1'b1;
    step();
    idle();
    total++;
    if ({count, data_out} !== {5'd4, 8'h31}) begin bad++; $display("FAIL mid_pre got=%0d/%h exp=4/31", count, data_out); end
    rst = 1'b1; wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'hEE;
    step();
    idle();
    total++;
    if ({count, empty, data_out} !== {5'd0, 1'b1, 8'h00}) begin
      bad++; $display("FAIL mid_rst got=%0d/%b/%h exp=0/1/00", count, empty, data_out);
    end
    total++;
    if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL mid_rst_err got=%b%b exp=00", overflow, underflow); end
  endtask

  initial begin
    idle();
    data_in = 8'h00;
    rst = 1'b1;
    step();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
